// File: rtl/stochastic_job_scheduler.sv
// stochastic_job_scheduler: two-requester round-robin front end for a stochastic engine
// (serial operand load, 2^WIN_LOG2-cycle ones count, scaled report). Rev 1.0
`default_nettype none

module stochastic_job_scheduler #(
  parameter int WIN_LOG2 = 17,
  parameter int FRAME    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [8:0] a0,
  input  logic [8:0] b0,
  input  logic [8:0] a1,
  input  logic [8:0] b1,
  input  logic       mode0,
  input  logic       mode1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [9:0] result,
  output logic       eng_ser_a,
  output logic       eng_ser_b,
  output logic       eng_mode,
  output logic       eng_load,
  output logic       eng_run,
  input  logic       eng_sn,
  output logic       busy
);

  localparam int LCW = $clog2(FRAME);
  localparam logic [LCW-1:0]      C_LAST_LOAD = LCW'(FRAME - 1);
  localparam logic [LCW-1:0]      C_LCNT_ONE  = LCW'(1);
  localparam logic [WIN_LOG2-1:0] C_RCNT_ONE  = WIN_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t              r_state;
  logic [LCW-1:0]      r_lcnt;
  logic [WIN_LOG2-1:0] r_rcnt;
  logic [WIN_LOG2:0]   r_ones;
  logic [8:0]          r_sh_a;
  logic [8:0]          r_sh_b;
  logic                r_prio;   // requester that wins a tie
  logic                r_owner;  // requester of the job in flight

  logic                w_any;
  logic                w_pick1;
  logic [8:0]          w_a;
  logic [8:0]          w_b;
  logic                w_mode;
  logic [WIN_LOG2:0]   w_ones_next;

  assign w_any       = req0 | req1;
  assign w_pick1     = req1 & (~req0 | r_prio);
  assign w_a         = w_pick1 ? a1 : a0;
  assign w_b         = w_pick1 ? b1 : b0;
  assign w_mode      = w_pick1 ? mode1 : mode0;
  assign w_ones_next = r_ones + {{WIN_LOG2{1'b0}}, eng_sn};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state   <= IDLE;
      r_lcnt    <= '0;
      r_rcnt    <= '0;
      r_ones    <= '0;
      r_sh_a    <= '0;
      r_sh_b    <= '0;
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      result    <= '0;
      eng_ser_a <= 1'b0;
      eng_ser_b <= 1'b0;
      eng_mode  <= 1'b0;
      eng_load  <= 1'b0;
      eng_run   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state   <= LOAD;
            busy      <= 1'b1;
            r_owner   <= w_pick1;
            r_prio    <= ~w_pick1;
            gnt0      <= ~w_pick1;
            gnt1      <= w_pick1;
            eng_mode  <= w_mode;
            eng_load  <= 1'b1;
            eng_ser_a <= w_a[0];
            eng_ser_b <= w_b[0];
            r_sh_a    <= {1'b0, w_a[8:1]};
            r_sh_b    <= {1'b0, w_b[8:1]};
            r_lcnt    <= '0;
          end
        end
        LOAD: begin
          if (r_lcnt == C_LAST_LOAD) begin
            r_state   <= RUN;
            eng_load  <= 1'b0;
            eng_ser_a <= 1'b0;
            eng_ser_b <= 1'b0;
            eng_run   <= 1'b1;
            r_rcnt    <= '0;
            r_ones    <= '0;
          end else begin
            // shift registers drain to zero, giving the guard bits for free
            r_lcnt    <= r_lcnt + C_LCNT_ONE;
            eng_ser_a <= r_sh_a[0];
            eng_ser_b <= r_sh_b[0];
            r_sh_a    <= {1'b0, r_sh_a[8:1]};
            r_sh_b    <= {1'b0, r_sh_b[8:1]};
          end
        end
        RUN: begin
          r_ones <= w_ones_next;
          r_rcnt <= r_rcnt + C_RCNT_ONE;
          if (&r_rcnt) begin
            r_state <= REPORT;
            eng_run <= 1'b0;
            result  <= {w_ones_next[WIN_LOG2], w_ones_next[WIN_LOG2-1 -: 9]};
            done0   <= ~r_owner;
            done1   <= r_owner;
          end
        end
        REPORT: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stochastic_job_scheduler.sv
// tb_stochastic_job_scheduler: self-checking bench with a job-level reference model
`default_nettype none

module tb_stochastic_job_scheduler;

  localparam int WL = 9;
  localparam int FR = 10;
  localparam int WIN = 1 << WL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [8:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       mode0 = 1'b0, mode1 = 1'b0;
  logic       eng_sn = 1'b0;
  logic       gnt0, gnt1, done0, done1;
  logic [9:0] result;
  logic       eng_ser_a, eng_ser_b, eng_mode, eng_load, eng_run, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int model_prio = 0;

  stochastic_job_scheduler #(.WIN_LOG2(WL), .FRAME(FR)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .mode0(mode0), .mode1(mode1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .result(result),
    .eng_ser_a(eng_ser_a), .eng_ser_b(eng_ser_b), .eng_mode(eng_mode),
    .eng_load(eng_load), .eng_run(eng_run), .eng_sn(eng_sn), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full job from the edge that grants it through the IDLE cycle after REPORT.
  // pat: 0 all ones, 1 alternating 1/0, 2 all zeros, 3 random.
  task automatic test_job(input int pat, input bit pulse1);
    int         who, ones, bad_run, exp_int;
    logic [8:0] ea, eb;
    logic       em, sn, eba, ebb;
    logic [9:0] exp_res, exp_vec, got_vec;
    who = (req0 && req1) ? model_prio : (req1 ? 1 : 0);
    ea  = (who == 1) ? a1 : a0;
    eb  = (who == 1) ? b1 : b0;
    em  = (who == 1) ? mode1 : mode0;
    step();
    model_prio = 1 - who;
    if (who == 1) begin
      req1 = 1'b0; a1 = 9'($urandom); b1 = 9'($urandom); mode1 = 1'($urandom);
    end else begin
      req0 = 1'b0; a0 = 9'($urandom); b0 = 9'($urandom); mode0 = 1'($urandom);
    end
    for (int k = 0; k < FR; k++) begin
      eba = (k < 9) ? ea[k] : 1'b0;
      ebb = (k < 9) ? eb[k] : 1'b0;
      exp_vec = {(k == 0 && who == 0), (k == 0 && who == 1), 2'b00, 1'b1, 1'b0, 1'b1, em, eba, ebb};
      got_vec = {gnt0, gnt1, done0, done1, eng_load, eng_run, busy, eng_mode, eng_ser_a, eng_ser_b};
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL load_cycle_%0d: got %b expected %b", k, got_vec, exp_vec);
      end
      step();
    end
    ones = 0;
    bad_run = 0;
    for (int i = 0; i < WIN; i++) begin
      got_vec = {gnt0, gnt1, done0, done1, eng_load, eng_run, busy, eng_mode, eng_ser_a, eng_ser_b};
      if (got_vec !== {4'b0000, 1'b0, 1'b1, 1'b1, em, 2'b00}) bad_run++;
      case (pat)
        0:       sn = 1'b1;
        1:       sn = (i % 2 == 0);
        2:       sn = 1'b0;
        default: sn = 1'($urandom);
      endcase
      eng_sn = sn;
      ones += int'(sn);
      if (pulse1) req1 = (i >= 100 && i < 103);
      step();
    end
    eng_sn = 1'b0;
    n_checks++;
    if (bad_run != 0) begin
      n_fail++;
      $display("FAIL run_phase: %0d bad cycles, required 0", bad_run);
    end
    exp_int = (ones / WIN) * 512 + ((ones % WIN) >> (WL - 9));
    exp_res = 10'(exp_int);
    n_checks++;
    if ({done0, done1, eng_run, busy, eng_mode} !== {who == 0, who == 1, 1'b0, 1'b1, em}) begin
      n_fail++;
      $display("FAIL report_flags: got %b expected %b", {done0, done1, eng_run, busy, eng_mode},
               {who == 0, who == 1, 1'b0, 1'b1, em});
    end
    n_checks++;
    if (result !== exp_res) begin
      n_fail++;
      $display("FAIL report_result: got %h expected %h", result, exp_res);
    end
    step();
    n_checks++;
    if ({gnt0, gnt1, done0, done1, busy, eng_load, eng_run, eng_mode, result} !==
        {5'b00000, 2'b00, em, exp_res}) begin
      n_fail++;
      $display("FAIL after_report: got %b expected %b",
               {gnt0, gnt1, done0, done1, busy, eng_load, eng_run, eng_mode, result},
               {5'b00000, 2'b00, em, exp_res});
    end
  endtask

  task automatic test_reset();
    req0 = 1'($urandom); req1 = 1'($urandom);
    a0 = 9'($urandom); a1 = 9'($urandom);
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if ({gnt0, gnt1, done0, done1, result, eng_ser_a, eng_ser_b, eng_mode, eng_load, eng_run, busy} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0",
               {gnt0, gnt1, done0, done1, result, eng_ser_a, eng_ser_b, eng_mode, eng_load, eng_run, busy});
    end
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    model_prio = 0;
    step();
  endtask

  task automatic test_basic();
    req1 = 1'b0;
    req0 = 1'b1; a0 = 9'h155; b0 = 9'h0AA; mode0 = 1'b0;
    test_job(0, 1'b0);
    req0 = 1'b1; a0 = 9'($urandom); b0 = 9'($urandom); mode0 = 1'b1;
    test_job(1, 1'b0);
    req0 = 1'b1;
    test_job(2, 1'b0);
    for (int n = 0; n < 3; n++) begin
      req0 = 1'($urandom);
      req1 = req0 ? 1'($urandom) : 1'b1;
      a0 = 9'($urandom); b0 = 9'($urandom); mode0 = 1'($urandom);
      a1 = 9'($urandom); b1 = 9'($urandom); mode1 = 1'($urandom);
      test_job(3, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_round_robin();
    test_reset();
    req0 = 1'b1; req1 = 1'b1; mode0 = 1'b0; mode1 = 1'b1;
    a1 = 9'($urandom); b1 = 9'($urandom);
    test_job(3, 1'b0);
    test_job(3, 1'b0);
  endtask

  task automatic test_dropped_req();
    int stray;
    req0 = 1'b1; req1 = 1'b0;
    test_job(3, 1'b1);
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      if (gnt1 !== 1'b0 || busy !== 1'b0) stray++;
      step();
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL dropped_req: %0d cycles with gnt1/busy, required 0", stray);
    end
  endtask

  task automatic test_reset_midrun();
    int stray;
    req0 = 1'b1; req1 = 1'b0; a0 = 9'($urandom); eng_sn = 1'b1;
    step();
    req0 = 1'b0;
    for (int i = 0; i < FR + 100; i++) step();
    n_checks++;
    if (eng_run !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_running: eng_run %b expected 1", eng_run);
    end
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    model_prio = 0;
    n_checks++;
    if ({gnt0, gnt1, done0, done1, result, eng_ser_a, eng_ser_b, eng_mode, eng_load, eng_run, busy} !== 19'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got %h expected 0",
               {gnt0, gnt1, done0, done1, result, eng_ser_a, eng_ser_b, eng_mode, eng_load, eng_run, busy});
    end
    stray = 0;
    for (int i = 0; i < WIN + 100; i++) begin
      if (done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b0) stray++;
      step();
    end
    eng_sn = 1'b0;
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL aborted_job: %0d cycles with done/busy, required 0", stray);
    end
    req0 = 1'b1; a0 = 9'($urandom); b0 = 9'($urandom);
    test_job(3, 1'b0);
  endtask

  task automatic test_rr_after_reset();
    test_reset();
    req1 = 1'b1; a1 = 9'($urandom); b1 = 9'($urandom); mode1 = 1'($urandom);
    test_job(3, 1'b0);
    req0 = 1'b1; req1 = 1'b1;
    a0 = 9'($urandom); b0 = 9'($urandom); mode0 = 1'($urandom);
    test_job(3, 1'b0);
    test_job(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_dropped_req();
    test_reset_midrun();
    test_rr_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stochastic_job_scheduler.md
STOCHASTIC_JOB_SCHEDULER -- requirements
Module: stochastic_job_scheduler

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 17, meaning the accumulation window is 2^WIN_LOG2 cycles; legal range 9..20.
REQ-002 SHALL have parameter FRAME, default 10, meaning the serial load frame length in cycles (9 data bits plus 1 guard bit).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-high reset (1 = reset).
REQ-005 SHALL have ports req0 and req1, input, 1 bit each: job request from requester 0 and requester 1.
REQ-006 SHALL have ports a0, b0, a1, b1, input, 9 bits each: operand probabilities of each requester.
REQ-007 SHALL have ports mode0 and mode1, input, 1 bit each: operation select (0 = multiply, 1 = add).
REQ-008 SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle job-accept pulse.
REQ-009 SHALL have ports done0 and done1, output, 1 bit each: one-cycle result-valid pulse.
REQ-010 SHALL have port result, output, 10 bits: {overflow, 9-bit probability}.
REQ-011 SHALL have ports eng_ser_a and eng_ser_b, output, 1 bit each: serial operand lines to the engine.
REQ-012 SHALL have ports eng_mode, eng_load and eng_run, output, 1 bit each: engine mode, load-frame strobe and run strobe.
REQ-013 SHALL have port eng_sn, input, 1 bit: the engine's stochastic output bit.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, LOAD, RUN and REPORT, with transitions IDLE->LOAD->RUN->REPORT->IDLE only.
REQ-016 SHALL, in IDLE, move to LOAD at the clock edge E0 where at least one req is sampled high.
- At E0 it latches the winner's a, b and mode.
- Exactly one gnt is driven high for the one cycle following E0.
REQ-017 SHALL arbitrate round-robin when both req are high at E0: the requester not served last wins.
- After reset, requester 0 has priority.
- The pointer updates only on a grant.
REQ-018 SHALL ignore req during LOAD, RUN and REPORT.
- A requester holds req until its gnt.
- A req dropped before grant is never granted.
REQ-019 SHALL hold LOAD for exactly FRAME cycles with eng_load high, with the first LOAD cycle coincident with gnt.
- During LOAD cycle k (k = 0..8), eng_ser_a = latched a[k] and eng_ser_b = latched b[k] (LSB first).
- During cycles 9..FRAME-1, both lines are 0.
REQ-020 SHALL drive eng_mode with the latched mode from the first LOAD cycle through REPORT, and hold it unchanged in IDLE.
REQ-021 SHALL hold RUN for exactly 2^WIN_LOG2 cycles with eng_run high, sampling eng_sn once per RUN cycle.
- Samples go into a (WIN_LOG2+1)-bit ones counter, cleared on entry to RUN.
- The counter cannot wrap: max count = 2^WIN_LOG2 sets the MSB.
REQ-022 SHALL, in the single REPORT cycle, drive result = {cnt[WIN_LOG2], cnt[WIN_LOG2-1 : WIN_LOG2-9]} and pulse the done of the granted requester.
- result holds that value until the next REPORT.
REQ-023 SHALL give a fixed latency: gnt in cycle E0+1; done in cycle E0+1+FRAME+2^WIN_LOG2.
REQ-024 SHALL keep eng_load, eng_run, gnt* and done* low in every state other than the one defined above for each.
REQ-025 SHALL allow a req high in the REPORT cycle to be granted at the first IDLE edge; there are no back-to-back REPORT->LOAD transitions.
REQ-026 SHALL keep all outputs registered, with no combinational path from any input to any output.

Reset
REQ-027 SHALL force the following at any edge where rst_n = 1, in any state including mid-LOAD or mid-RUN:
- state = IDLE, rr pointer = requester 0, ones counter = 0, result = 0;
- gnt0 = gnt1 = done0 = done1 = 0, eng_* = 0, busy = 0.
REQ-028 SHALL never issue a done for a job aborted by reset.

Verification (WIN_LOG2 = 9, FRAME = 10)
REQ-029 SHALL pass: req0 with a0 = 9'h155, b0 = 9'h0AA, mode0 = 0, eng_sn tied 1 -> gnt0 at E0+1; eng_ser_a over LOAD = 1,0,1,0,1,0,1,0,1,0; done0 at E0+523; result = 10'h200.
REQ-030 SHALL pass: eng_sn alternating 1/0 during RUN -> result = 10'h100; with eng_sn tied 0 -> result = 10'h000.
REQ-031 SHALL pass: req0 and req1 both held high from reset -> gnt0 first, then gnt1 at the first IDLE edge after done0, with eng_mode following mode1.
REQ-032 SHALL pass: req1 pulsed during RUN of job 0 then dropped -> no gnt1, and busy falls after done0.
REQ-033 SHALL pass: rst_n = 1 for one cycle at RUN cycle 100 -> all outputs 0 the next cycle, no done, and a subsequent req0 is granted normally.
REQ-034 SHALL pass: req1 alone after reset -> gnt1; then req0 and req1 both high -> gnt0 (round-robin).
